cram_writer: RTL and testbench

- Z80-side write engine for the 256 x 15-bit palette RAM (CRAM) that the video output stage reads.
- Takes byte-wide port writes: index, data low, data high. Assembles 15-bit palette words and queues them in a small FIFO.
- Drains the FIFO into CRAM only in cycles granted by the video timing (`wslot`).
- Includes a hardware clear sequencer that zeroes all 256 entries.

---
 rtl/cram_writer.sv | 179 +++++++++++++++++
 tb/tb_cram_writer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cram_writer.sv
// Z80-side palette RAM (CRAM) write engine: byte-wide register writes build
// 15-bit palette words, which go through a small FIFO and drain into CRAM
// only in cycles granted by the video timing. Also contains a clear sequencer.
// Latency: commit at edge N -> earliest cram_we in the cycle after edge N+1 (needs wslot).
// Backpressure: none towards the Z80; a commit into a full FIFO is dropped and sets ovf.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   zwr_stb/zreg/zdata  Z80 register write (0 index, 1 data low, 2 data high/commit, 3 control)
//   wslot               a CRAM write is permitted at this edge
//   cram_addr/data/we   registered CRAM write port, data = R[14:10] G[9:5] B[4:0]
//   cur_index, autoinc  palette index register and auto-increment enable
//   busy                clear sequence in progress
//   ovf                 sticky: a commit was lost because the FIFO was full
module cram_writer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        zwr_stb,
  input  logic [1:0]  zreg,
  input  logic [7:0]  zdata,
  input  logic        wslot,
  output logic [7:0]  cram_addr,
  output logic [14:0] cram_data,
  output logic        cram_we,
  output logic [7:0]  cur_index,
  output logic        autoinc,
  output logic        busy,
  output logic        ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    CLEAR,
    DONE
  } state_t;

  typedef struct packed {
    logic [7:0]  addr;
    logic [14:0] data;
  } entry_t;

  state_t        state;
  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    lo_latch;
  logic [7:0]    clr_cnt;

  logic   fifo_full;
  logic   fifo_empty;
  logic   pop;
  logic   push_req;
  logic   push;
  logic   ctrl_wr;
  logic   clr_req;
  entry_t head;
  entry_t push_ent;

  assign fifo_full  = (count == CW'(DEPTH));
  assign fifo_empty = (count == '0);

  // Pops are suspended while the clear sequencer owns the write slots.
  assign pop      = wslot && !fifo_empty && (state != CLEAR);
  assign push_req = zwr_stb && (zreg == 2'd2);
  // A simultaneous pop frees a slot, so a push into a full FIFO still fits.
  assign push     = push_req && (!fifo_full || pop);
  assign ctrl_wr  = zwr_stb && (zreg == 2'd3);
  assign clr_req  = ctrl_wr && zdata[1] && !busy;

  assign head     = mem[rd_ptr];
  assign push_ent = '{addr: cur_index, data: {zdata[6:0], lo_latch}};

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      lo_latch  <= '0;
      clr_cnt   <= '0;
      cur_index <= '0;
      autoinc   <= 1'b0;
      busy      <= 1'b0;
      ovf       <= 1'b0;
      cram_addr <= '0;
      cram_data <= '0;
      cram_we   <= 1'b0;
    end else begin
      cram_we <= 1'b0;

      // FIFO drain into CRAM
      if (pop) begin
        cram_we   <= 1'b1;
        cram_addr <= head.addr;
        cram_data <= head.data;
        rd_ptr    <= rd_ptr + AW'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // Clear sequencer
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= DRAIN;
            busy  <= 1'b1;
          end
        end
        DRAIN: begin
          // An empty FIFO also means no pop is being issued at this edge.
          if (fifo_empty) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end
        end
        CLEAR: begin
          if (wslot) begin
            cram_we   <= 1'b1;
            cram_addr <= clr_cnt;
            cram_data <= '0;
            clr_cnt   <= clr_cnt + 8'd1;
            if (clr_cnt == 8'hFF) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Z80 register writes
      if (zwr_stb) begin
        case (zreg)
          2'd0: cur_index <= zdata;
          2'd1: lo_latch  <= zdata;
          2'd2: begin
            if (push) begin
              if (autoinc) begin
                cur_index <= cur_index + 8'd1;
              end
            end else begin
              ovf <= 1'b1;
            end
          end
          default: begin
            autoinc <= zdata[0];
            if (zdata[2]) begin
              ovf <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cram_writer.sv
// Self-checking bench for cram_writer: directed scenarios plus a random phase,
// all compared cycle by cycle against a queue-based reference model.
module tb_cram_writer;

  localparam int DEPTH = 4;
  localparam int P_IDLE = 0, P_DRAIN = 1, P_CLR = 2, P_DONE = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        zwr_stb;
  logic [1:0]  zreg;
  logic [7:0]  zdata;
  logic        wslot;
  logic [7:0]  cram_addr;
  logic [14:0] cram_data;
  logic        cram_we;
  logic [7:0]  cur_index;
  logic        autoinc;
  logic        busy;
  logic        ovf;

  cram_writer #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .zwr_stb  (zwr_stb),
    .zreg     (zreg),
    .zdata    (zdata),
    .wslot    (wslot),
    .cram_addr(cram_addr),
    .cram_data(cram_data),
    .cram_we  (cram_we),
    .cur_index(cur_index),
    .autoinc  (autoinc),
    .busy     (busy),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0]  a;
    logic [14:0] d;
  } ent_t;

  ent_t        mq[$];
  logic [7:0]  m_idx, m_lo;
  logic        m_ai, m_busy, m_ovf, m_we;
  logic [7:0]  m_addr;
  logic [14:0] m_data;
  int          m_phase, m_cnt;

  task automatic model_step();
    int   qn;
    logic pop;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_idx = 0; m_lo = 0; m_ai = 0; m_busy = 0; m_ovf = 0;
      m_we = 0; m_addr = 0; m_data = 0; m_phase = P_IDLE; m_cnt = 0;
      return;
    end
    qn   = mq.size();
    pop  = wslot && (qn != 0) && (m_phase != P_CLR);
    m_we = 0;
    if (pop) begin
      e = mq.pop_front();
      m_we = 1; m_addr = e.a; m_data = e.d;
    end
    case (m_phase)
      P_IDLE:  if (zwr_stb && zreg == 3 && zdata[1]) begin m_phase = P_DRAIN; m_busy = 1; end
      P_DRAIN: if (qn == 0) begin m_phase = P_CLR; m_cnt = 0; end
      P_CLR: if (wslot) begin
        m_we = 1; m_addr = 8'(m_cnt); m_data = 0;
        if (m_cnt == 255) m_phase = P_DONE;
        m_cnt++;
      end
      default: begin m_busy = 0; m_phase = P_IDLE; end
    endcase
    if (zwr_stb) begin
      case (zreg)
        2'd0: m_idx = zdata;
        2'd1: m_lo = zdata;
        2'd2: begin
          if (qn < DEPTH || pop) begin
            e.a = m_idx; e.d = {zdata[6:0], m_lo};
            mq.push_back(e);
            if (m_ai) m_idx = m_idx + 8'd1;
          end else m_ovf = 1;
        end
        default: begin
          m_ai = zdata[0];
          if (zdata[2]) m_ovf = 0;
        end
      endcase
    end
  endtask

  // One clock: model follows the edge, DUT outputs compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("cram_we", cram_we, m_we);
    if (m_we) begin
      check("cram_addr", cram_addr, m_addr);
      check("cram_data", cram_data, m_data);
    end
    check("busy", busy, m_busy);
    check("ovf", ovf, m_ovf);
    check("cur_index", cur_index, m_idx);
    check("autoinc", autoinc, m_ai);
    if (cram_we) pulses++;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic zw(input logic [1:0] r, input logic [7:0] d);
    zwr_stb = 1; zreg = r; zdata = d;
    cycle();
    zwr_stb = 0;
  endtask

  task automatic commit(input logic [7:0] lo, input logic [7:0] hi);
    zw(2'd1, lo);
    zw(2'd2, hi);
  endtask

  initial begin
    int k;
    rst = 1; zwr_stb = 0; zreg = 0; zdata = 0; wslot = 0;
    idle(2);
    check("rst_we", cram_we, 0);
    check("rst_busy", busy, 0);
    check("rst_index", cur_index, 0);
    rst = 0;
    idle(1);

    // 1: basic commit
    wslot = 1; pulses = 0;
    zw(2'd0, 8'h10);
    commit(8'h34, 8'h12);
    idle(3);
    check("t1_pulses", pulses, 1);
    check("t1_index", cur_index, 8'h10);

    // 2: auto-increment wrap
    zw(2'd3, 8'h01);
    zw(2'd0, 8'hFF);
    commit(8'hAA, 8'h55);
    commit(8'hBB, 8'h66);
    idle(3);
    check("t2_index", cur_index, 8'h01);

    // 3: overflow
    wslot = 0;
    zw(2'd0, 8'h20);
    for (int i = 0; i <= DEPTH; i++) commit(8'(i), 8'(i + 8'h40));
    check("t3_ovf", ovf, 1);
    check("t3_index", cur_index, 8'h20 + DEPTH);
    pulses = 0; wslot = 1;
    idle(6);
    check("t3_pulses", pulses, DEPTH);
    zw(2'd3, 8'h04);
    check("t3_ovf_clr", ovf, 0);

    // 4: clear with queued data
    wslot = 0;
    zw(2'd0, 8'h80);
    commit(8'h11, 8'h22);
    zw(2'd0, 8'h81);
    commit(8'h33, 8'h44);
    pulses = 0; wslot = 1;
    zw(2'd3, 8'h02);
    zw(2'd0, 8'h05);
    commit(8'hFF, 8'h7F);
    k = 0;
    while (busy && k < 600) begin cycle(); k++; end
    check("t4_busy_fall", busy == 0, 1);
    idle(4);
    check("t4_pulses", pulses, 2 + 256 + 1);

    // 5: slot gating, second request while busy ignored
    wslot = 0; pulses = 0;
    zw(2'd3, 8'h02);
    k = 0;
    while ((busy || k < 2) && k < 2000) begin
      wslot = (k % 4 == 0);
      if (k == 50) begin zwr_stb = 1; zreg = 3; zdata = 8'h02; end
      cycle();
      zwr_stb = 0;
      k++;
    end
    check("t5_busy_fall", busy == 0, 1);
    wslot = 1;
    idle(6);
    check("t5_pulses", pulses, 256);
    check("t5_busy_after", busy, 0);

    // 6: reset mid-clear
    zw(2'd0, 8'h33);
    zw(2'd3, 8'h02);
    k = 0;
    while (!(m_phase == P_CLR && m_cnt == 100) && k < 400) begin cycle(); k++; end
    check("t6_reach_100", k < 400, 1);
    rst = 1;
    cycle();
    rst = 0;
    check("t6_we", cram_we, 0);
    check("t6_busy", busy, 0);
    check("t6_index", cur_index, 0);
    pulses = 0;
    idle(20);
    check("t6_no_writes", pulses, 0);

    // random phase
    for (int i = 0; i < 1500; i++) begin
      wslot   = 1'($urandom_range(0, 1));
      zwr_stb = ($urandom_range(0, 1) == 1);
      zreg    = 2'($urandom_range(0, 3));
      zdata   = 8'($urandom);
      if (zreg == 2'd3 && $urandom_range(0, 15) != 0) zdata[1] = 1'b0;
      cycle();
      zwr_stb = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
